// File: rtl/lap_reader_if.sv
// RAM read-port bundle between lap_reader (master) and the lap RAM / writer side (slave).
interface lap_reader_if #(
  parameter int unsigned LOAD_SIZE = 16
) ();
  logic                 rd_en;
  logic [LOAD_SIZE-1:0] rd_addr;
  logic [LOAD_SIZE-1:0] rd_data;
  logic [LOAD_SIZE-1:0] wr_count;

  modport master (output rd_en, output rd_addr, input rd_data, input wr_count);
  modport slave  (input rd_en, input rd_addr, output rd_data, output wr_count);
endinterface

// File: rtl/lap_reader.sv
// Stopwatch lap read-back: fetches packed BCD mm:ss records one per next pulse and wraps.
// Optional BCD range check on captured records: define LAP_READER_CHECK_EN.
module lap_reader #(
  parameter int unsigned SIZE        = 4,
  parameter int unsigned LOAD_SIZE   = 16,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_next,
  input  logic                 i_restart,
  lap_reader_if.master         io_mem,
  output logic [SIZE-1:0]      o_seconds_units,
  output logic [SIZE-1:0]      o_seconds_tens,
  output logic [SIZE-1:0]      o_minutes_units,
  output logic [SIZE-1:0]      o_minutes_tens,
  output logic [LOAD_SIZE-1:0] o_shown_idx,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_CAPT} state_t;

  localparam logic [1:0] LAT_INIT = (MEM_LATENCY >= 2) ? 2'(MEM_LATENCY - 2) : 2'd0;

  state_t               r_state;
  logic [1:0]           r_lat;
  logic [LOAD_SIZE-1:0] r_idx;
  logic                 r_rd_en;
  logic [LOAD_SIZE-1:0] r_rd_addr;
  logic [SIZE-1:0]      r_su, r_st, r_mu, r_mt;
  logic [LOAD_SIZE-1:0] r_shown_idx;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_err;

  logic [LOAD_SIZE-1:0] w_req_addr;
  logic [LOAD_SIZE:0]   w_next_addr;
  logic                 w_wrap;
  logic [SIZE-1:0]      w_su, w_st, w_mu, w_mt;
  logic                 w_err;

  assign w_su = io_mem.rd_data[SIZE-1:0];
  assign w_st = io_mem.rd_data[2*SIZE-1:SIZE];
  assign w_mu = io_mem.rd_data[3*SIZE-1:2*SIZE];
  assign w_mt = io_mem.rd_data[4*SIZE-1:3*SIZE];

`ifdef LAP_READER_CHECK_EN
  assign w_err = (w_su > SIZE'(9)) || (w_st > SIZE'(5)) ||
                 (w_mu > SIZE'(9)) || (w_mt > SIZE'(5));
`else
  assign w_err = 1'b0;
`endif

  always_comb begin
    w_req_addr  = (r_idx >= io_mem.wr_count) ? '0 : r_idx;
    // One extra bit so address+1 never overflows at the maximum count
    w_next_addr = {1'b0, r_rd_addr} + (LOAD_SIZE+1)'(1);
    w_wrap      = (w_next_addr >= {1'b0, io_mem.wr_count});
  end

  // REQ holds rd_en for the RAM sample edge; WAIT absorbs latency beyond one cycle,
  // and the edge leaving CAPT is the one where rd_data is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lat       <= '0;
      r_idx       <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_su        <= '0;
      r_st        <= '0;
      r_mu        <= '0;
      r_mt        <= '0;
      r_shown_idx <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else if (i_restart) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_su    <= '0;
      r_st    <= '0;
      r_mu    <= '0;
      r_mt    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_next && (io_mem.wr_count != '0)) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= w_req_addr;
            r_busy    <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          r_rd_en <= 1'b0;
          if (MEM_LATENCY < 2) begin
            r_state <= S_CAPT;
          end else begin
            r_lat   <= LAT_INIT;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_lat == '0) r_state <= S_CAPT;
          else             r_lat   <= r_lat - 2'd1;
        end
        S_CAPT: begin
          r_su        <= w_su;
          r_st        <= w_st;
          r_mu        <= w_mu;
          r_mt        <= w_mt;
          r_err       <= w_err;
          r_valid     <= 1'b1;
          r_shown_idx <= r_rd_addr;
          r_idx       <= w_wrap ? '0 : w_next_addr[LOAD_SIZE-1:0];
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_mem.rd_en    = r_rd_en;
  assign io_mem.rd_addr  = r_rd_addr;
  assign o_seconds_units = r_su;
  assign o_seconds_tens  = r_st;
  assign o_minutes_units = r_mu;
  assign o_minutes_tens  = r_mt;
  assign o_shown_idx     = r_shown_idx;
  assign o_valid         = r_valid;
  assign o_busy          = r_busy;
  assign o_err           = r_err;

endmodule

// File: tb/tb_lap_reader.sv
// Directed bench for lap_reader: latency 1 instance for the main flow, latency 3 instance for timing.
module tb_lap_reader;

`ifdef LAP_READER_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic next0, restart0, next1, restart1;

  logic [3:0]  su0, st0, mu0, mt0, su1, st1, mu1, mt1;
  logic [15:0] shown0, shown1;
  logic        valid0, busy0, err0, valid1, busy1, err1;

  logic [15:0] mem [16];
  logic [15:0] s0, s1;
  int          n_rden0, n_rden1;
  int          n_cmp, n_bad;

  lap_reader_if #(.LOAD_SIZE(16)) bus0 ();
  lap_reader_if #(.LOAD_SIZE(16)) bus1 ();

  lap_reader #(.SIZE(4), .LOAD_SIZE(16), .MEM_LATENCY(1)) u0 (
    .clk(clk), .rst(rst), .i_next(next0), .i_restart(restart0), .io_mem(bus0),
    .o_seconds_units(su0), .o_seconds_tens(st0), .o_minutes_units(mu0), .o_minutes_tens(mt0),
    .o_shown_idx(shown0), .o_valid(valid0), .o_busy(busy0), .o_err(err0));

  lap_reader #(.SIZE(4), .LOAD_SIZE(16), .MEM_LATENCY(3)) u1 (
    .clk(clk), .rst(rst), .i_next(next1), .i_restart(restart1), .io_mem(bus1),
    .o_seconds_units(su1), .o_seconds_tens(st1), .o_minutes_units(mu1), .o_minutes_tens(mt1),
    .o_shown_idx(shown1), .o_valid(valid1), .o_busy(busy1), .o_err(err1));

  always #5 clk = ~clk;

  // RAM read ports; junk data outside the valid slot exposes wrong capture timing
  always @(posedge clk) begin
    bus0.rd_data <= bus0.rd_en ? mem[bus0.rd_addr[3:0]] : 16'hFFFF;
    s0           <= bus1.rd_en ? mem[bus1.rd_addr[3:0]] : 16'hFFFF;
    s1           <= s0;
    bus1.rd_data <= s1;
    if (bus0.rd_en) n_rden0 <= n_rden0 + 1;
    if (bus1.rd_en) n_rden1 <= n_rden1 + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [15:0] a, input logic [15:0] d, input logic e);
    next0 = 1'b1;
    tick();
    next0 = 1'b0;
    chk("req_en",   {31'd0, bus0.rd_en}, 32'd1);
    chk("req_addr", {16'd0, bus0.rd_addr}, {16'd0, a});
    chk("req_busy", {31'd0, busy0}, 32'd1);
    tick();
    chk("req_drop", {31'd0, bus0.rd_en}, 32'd0);
    tick();
    chk("cap_mt",    {28'd0, mt0}, {28'd0, d[15:12]});
    chk("cap_mu",    {28'd0, mu0}, {28'd0, d[11:8]});
    chk("cap_st",    {28'd0, st0}, {28'd0, d[7:4]});
    chk("cap_su",    {28'd0, su0}, {28'd0, d[3:0]});
    chk("cap_valid", {31'd0, valid0}, 32'd1);
    chk("cap_shown", {16'd0, shown0}, {16'd0, a});
    chk("cap_busy",  {31'd0, busy0}, 32'd0);
    chk("cap_err",   {31'd0, err0}, {31'd0, e});
  endtask

  initial begin
    int base;
    n_cmp = 0; n_bad = 0; n_rden0 = 0; n_rden1 = 0;
    rst = 1'b1; next0 = 1'b0; restart0 = 1'b0; next1 = 1'b0; restart1 = 1'b0;
    bus0.wr_count = '0; bus1.wr_count = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 16'h0123; mem[1] = 16'h5959; mem[2] = 16'h0010;
    mem[3] = 16'h2345; mem[4] = 16'h4400; mem[5] = 16'h0559;

    repeat (2) tick();
    chk("rst_rden",  {31'd0, bus0.rd_en}, 32'd0);
    chk("rst_addr",  {16'd0, bus0.rd_addr}, 32'd0);
    chk("rst_dig",   {16'd0, mt0, mu0, st0, su0}, 32'd0);
    chk("rst_shown", {16'd0, shown0}, 32'd0);
    chk("rst_valid", {31'd0, valid0}, 32'd0);
    chk("rst_busy",  {31'd0, busy0}, 32'd0);
    chk("rst_err",   {31'd0, err0}, 32'd0);
    rst = 1'b0;
    tick();

    // Empty memory: next is ignored
    next0 = 1'b1;
    tick();
    next0 = 1'b0;
    repeat (3) tick();
    chk("empty_rden",  n_rden0, 0);
    chk("empty_valid", {31'd0, valid0}, 32'd0);
    chk("empty_busy",  {31'd0, busy0}, 32'd0);

    // Two records, three pulses: 0,1, wrap to 0
    bus0.wr_count = 16'd2;
    do_fetch(16'd0, 16'h0123, 1'b0);
    do_fetch(16'd1, 16'h5959, 1'b0);
    do_fetch(16'd0, 16'h0123, 1'b0);
    chk("three_rden", n_rden0, 3);

    // Back-to-back next while busy is dropped
    base = n_rden0;
    next0 = 1'b1;
    tick();
    tick();
    next0 = 1'b0;
    tick();
    chk("b2b_shown", {16'd0, shown0}, 32'd1);
    chk("b2b_dig",   {16'd0, mt0, mu0, st0, su0}, 32'h5959);
    repeat (3) tick();
    chk("b2b_rden", n_rden0 - base, 1);

    // Latency 3 instance, same back-to-back pattern
    bus1.wr_count = 16'd2;
    next1 = 1'b1;
    tick();
    tick();
    next1 = 1'b0;
    tick();
    tick();
    chk("l3_valid_pre", {31'd0, valid1}, 32'd0);
    chk("l3_busy_pre",  {31'd0, busy1}, 32'd1);
    tick();
    chk("l3_valid", {31'd0, valid1}, 32'd1);
    chk("l3_dig",   {16'd0, mt1, mu1, st1, su1}, 32'h0123);
    chk("l3_busy",  {31'd0, busy1}, 32'd0);
    chk("l3_shown", {16'd0, shown1}, 32'd0);
    chk("l3_err",   {31'd0, err1}, 32'd0);
    repeat (3) tick();
    chk("l3_rden", n_rden1, 1);

    // Restart on the capture edge abandons the fetch
    do_fetch(16'd0, 16'h0123, 1'b0);
    next0 = 1'b1;
    tick();
    next0 = 1'b0;
    chk("rs_addr", {16'd0, bus0.rd_addr}, 32'd1);
    tick();
    restart0 = 1'b1;
    tick();
    restart0 = 1'b0;
    repeat (3) tick();
    chk("rs_valid", {31'd0, valid0}, 32'd0);
    chk("rs_dig",   {16'd0, mt0, mu0, st0, su0}, 32'd0);
    chk("rs_busy",  {31'd0, busy0}, 32'd0);
    do_fetch(16'd0, 16'h0123, 1'b0);

    // Writer shrinks below the read index
    bus0.wr_count = 16'd6;
    do_fetch(16'd1, 16'h5959, 1'b0);
    do_fetch(16'd2, 16'h0010, 1'b0);
    do_fetch(16'd3, 16'h2345, 1'b0);
    do_fetch(16'd4, 16'h4400, 1'b0);
    bus0.wr_count = 16'd3;
    do_fetch(16'd0, 16'h0123, 1'b0);

    // Out-of-range BCD record, then a clean one
    mem[1] = 16'h0A60;
    do_fetch(16'd1, 16'h0A60, CHK_EN);
    do_fetch(16'd2, 16'h0010, 1'b0);

    // Asynchronous reset mid-fetch
    next0 = 1'b1;
    tick();
    next0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_rden",  {31'd0, bus0.rd_en}, 32'd0);
    chk("arst_busy",  {31'd0, busy0}, 32'd0);
    chk("arst_valid", {31'd0, valid0}, 32'd0);
    chk("arst_dig",   {16'd0, mt0, mu0, st0, su0}, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
